// File: rtl/pcie_tlp_pkg.sv
// pcie_tlp_pkg: shared TLP constants, header DW builders and the MWr generator FSM state type.
package pcie_tlp_pkg;
  localparam logic [2:0] FMT_3DW_D = 3'b010;
  localparam logic [2:0] FMT_4DW_D = 3'b011;
  localparam logic [4:0] TYPE_MEM  = 5'b00000;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR0, S_HDR1, S_DATA, S_REL} state_e;
  // DW0: fmt, type, TC/TD/EP/attr all zero, length
  function automatic logic [31:0] hdr_dw0(input logic is4, input logic [9:0] len);
    return {is4 ? FMT_4DW_D : FMT_3DW_D, TYPE_MEM, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len};
  endfunction
  // DW1: requester ID, tag, lastBE (zero for single-DW writes), firstBE
  function automatic logic [31:0] hdr_dw1(input logic [15:0] rid, input logic [7:0] tag, input logic [9:0] len);
    return {rid, tag, len == 10'd1 ? 4'h0 : 4'hF, 4'hF};
  endfunction
endpackage

// File: rtl/pcie_mwr_tlp_gen_realign.sv
// tlp_dw_realign: 32-bit hold register and data-beat composition for 3DW MWr payload alignment.
//   load_i     payload beat consumed; capture its upper DW
//   pass_i     4DW TLP: payload passes straight through
//   first_i    first data beat: lower DW is the address DW
//   trail_i    trailing held-only beat: upper DW is zero
//   addr_lo_i  DW-aligned address low word
//   pl_tdata_i payload beat, beat_o composed TX data beat
module tlp_dw_realign (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        pass_i,
  input  logic        first_i,
  input  logic        trail_i,
  input  logic [31:0] addr_lo_i,
  input  logic [63:0] pl_tdata_i,
  output logic [63:0] beat_o
);
  logic [31:0] held_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) held_q <= '0;
    else if (load_i) held_q <= pl_tdata_i[63:32];
  assign beat_o = pass_i ? pl_tdata_i :
                  {trail_i ? 32'h0 : pl_tdata_i[31:0], first_i ? addr_lo_i : held_q};
endmodule

// File: rtl/pcie_mwr_tlp_gen.sv
// pcie_mwr_tlp_gen: builds posted MWr TLPs (3DW/4DW header) in 64-bit AXIS beats for the TX mux.
//   cmd_*      memory-write command (addr, len in DW, tag); cmd_err pulses on rejected length
//   req_id     requester ID placed in header DW1
//   pl_*       64-bit payload stream, DW 2i in [31:0]
//   tx_req/ack level handshake that wins the shared TX path
//   tx_*       TLP beat stream toward the mux; tx_src_dsc tied low
module pcie_mwr_tlp_gen
  import pcie_tlp_pkg::*;
#(
  parameter int MAX_LEN_DW = 32
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_addr,
  input  logic [9:0]  cmd_len,
  input  logic [7:0]  cmd_tag,
  input  logic [15:0] req_id,
  output logic        cmd_err,
  input  logic [63:0] pl_tdata,
  input  logic        pl_tvalid,
  output logic        pl_tready,
  output logic        tx_req,
  input  logic        tx_ack,
  input  logic        tx_tready,
  output logic [63:0] tx_tdata,
  output logic [7:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic        tx_tvalid,
  output logic        tx_src_dsc
);
  localparam logic [9:0] MAX_LEN = 10'(MAX_LEN_DW);
  state_e      state_q, state_d;
  logic [63:0] addr_q, data_beat;
  logic [9:0]  len_q, rem_q, dec;
  logic [7:0]  tag_q;
  logic        is4_q, first_q, err_q, bad, trail, beat;
  assign bad        = cmd_len == 10'd0 || cmd_len > MAX_LEN;
  // 3DW: one payload DW is left in the hold register once the payload is exhausted
  assign trail      = ~is4_q & ~first_q & (rem_q == 10'd1);
  // DWs of payload emitted by the current data beat; the 3DW first beat carries only one
  assign dec        = (rem_q == 10'd1 || (first_q && !is4_q)) ? 10'd1 : 10'd2;
  assign beat       = state_q == S_DATA && tx_tvalid && tx_tready;
  assign cmd_err    = err_q;
  assign tx_src_dsc = 1'b0;
  tlp_dw_realign u_realign (
    .clk       (clk),
    .rst_n     (sys_rst_n),
    .load_i    (pl_tvalid & pl_tready),
    .pass_i    (is4_q),
    .first_i   (first_q),
    .trail_i   (trail),
    .addr_lo_i (addr_q[31:0]),
    .pl_tdata_i(pl_tdata),
    .beat_o    (data_beat)
  );
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    tx_req    = 1'b0;
    tx_tvalid = 1'b0;
    tx_tdata  = '0;
    tx_tkeep  = '0;
    tx_tlast  = 1'b0;
    pl_tready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !bad) state_d = S_REQ;
      end
      S_REQ: begin
        tx_req = 1'b1;
        if (tx_ack) state_d = S_HDR0;
      end
      S_HDR0: begin
        tx_req    = 1'b1;
        tx_tvalid = 1'b1;
        tx_tkeep  = 8'hFF;
        tx_tdata  = {hdr_dw1(req_id, tag_q, len_q), hdr_dw0(is4_q, len_q)};
        if (tx_tready) state_d = is4_q ? S_HDR1 : S_DATA;
      end
      S_HDR1: begin
        tx_req    = 1'b1;
        tx_tvalid = 1'b1;
        tx_tkeep  = 8'hFF;
        tx_tdata  = {addr_q[31:0], addr_q[63:32]};
        if (tx_tready) state_d = S_DATA;
      end
      S_DATA: begin
        tx_req    = 1'b1;
        tx_tvalid = trail | pl_tvalid;
        pl_tready = tx_tready & ~trail;
        tx_tdata  = data_beat;
        tx_tkeep  = (rem_q == 10'd1 && !(first_q && !is4_q)) ? 8'h0F : 8'hFF;
        tx_tlast  = rem_q == dec;
        if (tx_tvalid && tx_tready && tx_tlast) state_d = S_REL;
      end
      S_REL: if (!tx_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      tag_q   <= '0;
      rem_q   <= '0;
      is4_q   <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= cmd_valid && cmd_ready && bad;
      if (cmd_valid && cmd_ready) begin
        addr_q  <= cmd_addr & ~64'h3;
        len_q   <= cmd_len;
        tag_q   <= cmd_tag;
        rem_q   <= cmd_len;
        is4_q   <= |cmd_addr[63:32];
        first_q <= 1'b1;
      end else if (beat) begin
        rem_q   <= rem_q - dec;
        first_q <= 1'b0;
      end
    end
  end
endmodule
